// File: rtl/uart_pkg.sv
// Shared types and widths for the UART frame scheduler.
// UART_TX_ODD_PARITY_EN selects odd parity; even parity otherwise.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_BUSY,
      TX,
      GAP
   } state_e;

   localparam int unsigned FRAME_W = 11;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned FCNT_W  = 16;
   localparam int unsigned ID_W    = 3;

   // Parity bit sent alongside a payload byte.
   function automatic logic parity_of(input logic [BYTE_W-1:0] d);
`ifdef UART_TX_ODD_PARITY_EN
      return ~^d;
`else
      return ^d;
`endif
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_valid
);

   logic [NUM_REQ-1:0] w_rot;
   logic [ID_W:0]      w_sum;

   // Rotate so that bit 0 is the requester at the pointer.
   assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_sum   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!o_valid && w_rot[k]) begin
            o_valid = 1'b1;
            w_sum   = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ))
               w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            o_idx = w_sum[ID_W-1:0];
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++)
         o_grant[j] = o_valid && (o_idx == ID_W'(j));
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART serializer with parity and inter-frame gap.
// Define UART_TX_ODD_PARITY_EN for odd parity (default even).
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  bd_clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [8*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  ser_start,
   output logic [BYTE_W-1:0]     ser_data,
   output logic                  ser_parity,
   input  logic                  ser_busy,
   output logic [ID_W-1:0]       grant_id,
   output logic                  sched_busy,
   output logic                  err_timeout,
   output logic [FCNT_W-1:0]     frame_cnt
);

   state_e              r_state;
   state_e              w_next;
   logic [ID_W-1:0]     r_ptr;
   logic [CNT_W-1:0]    r_cnt;
   logic [BYTE_W-1:0]   r_data;
   logic                r_parity;
   logic [ID_W-1:0]     r_grant;
   logic                r_start;
   logic                r_busy;
   logic                r_err;
   logic [FCNT_W-1:0]   r_frame_cnt;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_idx;
   logic                w_any;
   logic                w_accept;
   logic [BYTE_W-1:0]   w_byte;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic                w_cnt_clr;
   logic                w_cnt_inc;
   logic                w_err_set;
   logic                w_frame_done;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_any)
   );

   assign w_accept  = (r_state == IDLE) && w_any;
   assign req_ready = w_accept ? w_grant : '0;
   assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + ID_W'(1);

   // Payload of the winning requester.
   always_comb begin
      w_byte = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++)
         if (w_idx == ID_W'(j))
            w_byte = req_data[8*j +: 8];
   end

   always_ff @(posedge bd_clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next state plus counter/flag controls; wait and gap share one counter.
   always_comb begin
      w_next       = r_state;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_err_set    = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept)
               w_next = LOAD;
         end
         LOAD: begin
            w_next    = WAIT_BUSY;
            w_cnt_clr = 1'b1;
         end
         WAIT_BUSY: begin
            if (ser_busy) begin
               w_next = TX;
            end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
               w_err_set = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         TX: begin
            if (!ser_busy) begin
               w_frame_done = 1'b1;
               w_cnt_clr    = 1'b1;
               w_next       = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (r_cnt == CNT_W'(GAP_CYCLES-1))
               w_next = IDLE;
            else
               w_cnt_inc = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge bd_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_data      <= '0;
         r_parity    <= parity_of(BYTE_W'(0));
         r_grant     <= '0;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_start <= w_accept;
         r_busy  <= (w_next != IDLE);
         if (w_accept) begin
            r_data   <= w_byte;
            r_parity <= parity_of(w_byte);
            r_grant  <= w_idx;
            r_ptr    <= w_ptr_nxt;
         end
         if (w_cnt_clr)
            r_cnt <= '0;
         else if (w_cnt_inc)
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_err_set)
            r_err <= 1'b1;
         if (w_frame_done)
            r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
   end

   assign ser_start   = r_start;
   assign ser_data    = r_data;
   assign ser_parity  = r_parity;
   assign grant_id    = r_grant;
   assign sched_busy  = r_busy;
   assign err_timeout = r_err;
   assign frame_cnt   = r_frame_cnt;

endmodule
